// File: rtl/ccd_vsched_pkg.sv
// Shared types for the CCD vertical-transfer scheduler: state encoding, default
// geometry width and the phase-ordering helper.
package ccd_vsched_pkg;

  localparam int REG_WD_DEF      = 16;
  localparam int HPERIOD_MIN_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_READ = 2'd2,
    S_TAIL = 2'd3
  } state_t;

  // First phase strictly after cur whose line count is non-zero (IDLE if none).
  function automatic state_t next_phase(state_t cur, logic h_nz, logic r_nz, logic t_nz);
    next_phase = S_IDLE;
    case (cur)
      S_IDLE: begin
        if (h_nz)      next_phase = S_HEAD;
        else if (r_nz) next_phase = S_READ;
        else if (t_nz) next_phase = S_TAIL;
      end
      S_HEAD: begin
        if (r_nz)      next_phase = S_READ;
        else if (t_nz) next_phase = S_TAIL;
      end
      S_READ: begin
        if (t_nz)      next_phase = S_TAIL;
      end
      default: next_phase = S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ccd_line_timer.sv
// Horizontal line counter: counts 0..period_m1 while enabled and flags the
// last cycle of each line.
module ccd_line_timer #(
  parameter int REG_WD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [REG_WD-1:0] period_m1,
  output logic [REG_WD-1:0] hcount,
  output logic              line_end
);

  logic [REG_WD-1:0] hcount_q, hcount_d;

  assign line_end = en && (hcount_q == period_m1);
  assign hcount   = hcount_q;

  always_comb begin
    hcount_d = hcount_q;
    if (clr)           hcount_d = '0;
    else if (line_end) hcount_d = '0;
    else if (en)       hcount_d = hcount_q + REG_WD'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) hcount_q <= '0;
    else       hcount_q <= hcount_d;
  end

endmodule

// File: rtl/ccd_vtransfer_sched.sv
// Frame scheduler for the CCD vertical-transfer path: latches frame geometry and
// steps through head-blank, readout and tail-blank phases.
//
//   state  | meaning
//   S_IDLE | no frame in progress, waiting for i_frame_start
//   S_HEAD | head-blank lines
//   S_READ | readout lines
//   S_TAIL | tail-blank lines
module ccd_vtransfer_sched
  import ccd_vsched_pkg::*;
#(
  parameter int REG_WD      = REG_WD_DEF,
  parameter int HPERIOD_MIN = HPERIOD_MIN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_frame_start,
  input  logic              i_abort,
  input  logic [REG_WD-1:0] iv_hperiod,
  input  logic [REG_WD-1:0] iv_headblank_lines,
  input  logic [REG_WD-1:0] iv_readout_lines,
  input  logic [REG_WD-1:0] iv_tailblank_lines,
  output logic [REG_WD-1:0] ov_hcount,
  output logic [REG_WD-1:0] ov_vcount,
  output logic              o_headblank_flag,
  output logic              o_readout_flag,
  output logic              o_tailblank_flag,
  output logic              o_frame_busy,
  output logic              o_frame_done,
  output logic              o_start_ignored
);

  localparam logic [REG_WD-1:0] HMIN = REG_WD'(HPERIOD_MIN);

  state_t            state_q, state_d, nxt;
  logic [REG_WD-1:0] hper_m1_q, hper_m1_d, head_m1_q, head_m1_d;
  logic [REG_WD-1:0] read_m1_q, read_m1_d, tail_m1_q, tail_m1_d;
  logic              head_nz_q, head_nz_d, read_nz_q, read_nz_d, tail_nz_q, tail_nz_d;
  logic [REG_WD-1:0] vcount_q, vcount_d, cur_m1, hper_in;
  logic              head_q, read_q, tail_q, busy_q, done_q, done_d, ign_q, ign_d;
  logic              line_end, tmr_clr;

  ccd_line_timer #(.REG_WD(REG_WD)) u_line_timer (
    .clk       (clk),
    .reset     (reset),
    .en        (state_q != S_IDLE),
    .clr       (tmr_clr),
    .period_m1 (hper_m1_q),
    .hcount    (ov_hcount),
    .line_end  (line_end)
  );

  always_comb begin
    state_d   = state_q;
    hper_m1_d = hper_m1_q;
    head_m1_d = head_m1_q;
    read_m1_d = read_m1_q;
    tail_m1_d = tail_m1_q;
    head_nz_d = head_nz_q;
    read_nz_d = read_nz_q;
    tail_nz_d = tail_nz_q;
    vcount_d  = vcount_q;
    done_d    = 1'b0;
    ign_d     = 1'b0;
    tmr_clr   = 1'b0;
    hper_in   = (iv_hperiod < HMIN) ? HMIN : iv_hperiod;
    nxt       = next_phase(state_q, head_nz_q, read_nz_q, tail_nz_q);
    case (state_q)
      S_HEAD:  cur_m1 = head_m1_q;
      S_READ:  cur_m1 = read_m1_q;
      S_TAIL:  cur_m1 = tail_m1_q;
      default: cur_m1 = '0;
    endcase

    if (state_q == S_IDLE) begin
      if (i_frame_start && !i_abort) begin
        hper_m1_d = hper_in - REG_WD'(1);
        head_m1_d = iv_headblank_lines - REG_WD'(1);
        read_m1_d = iv_readout_lines - REG_WD'(1);
        tail_m1_d = iv_tailblank_lines - REG_WD'(1);
        head_nz_d = (iv_headblank_lines != '0);
        read_nz_d = (iv_readout_lines != '0);
        tail_nz_d = (iv_tailblank_lines != '0);
        state_d   = next_phase(S_IDLE, head_nz_d, read_nz_d, tail_nz_d);
        vcount_d  = '0;
        done_d    = (state_d == S_IDLE);
      end
    end else if (i_abort) begin
      state_d  = S_IDLE;
      vcount_d = '0;
      tmr_clr  = 1'b1;
    end else begin
      ign_d = i_frame_start;
      if (line_end) begin
        if (vcount_q == cur_m1) begin
          // hcount wraps to 0 on its own, so the next phase starts cleanly
          state_d  = nxt;
          vcount_d = '0;
          done_d   = (nxt == S_IDLE);
        end else begin
          vcount_d = vcount_q + REG_WD'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hper_m1_q <= '0;
      head_m1_q <= '0;
      read_m1_q <= '0;
      tail_m1_q <= '0;
      head_nz_q <= 1'b0;
      read_nz_q <= 1'b0;
      tail_nz_q <= 1'b0;
      vcount_q  <= '0;
      head_q    <= 1'b0;
      read_q    <= 1'b0;
      tail_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ign_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hper_m1_q <= hper_m1_d;
      head_m1_q <= head_m1_d;
      read_m1_q <= read_m1_d;
      tail_m1_q <= tail_m1_d;
      head_nz_q <= head_nz_d;
      read_nz_q <= read_nz_d;
      tail_nz_q <= tail_nz_d;
      vcount_q  <= vcount_d;
      head_q    <= (state_d == S_HEAD);
      read_q    <= (state_d == S_READ);
      tail_q    <= (state_d == S_TAIL);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= done_d;
      ign_q     <= ign_d;
    end
  end

  assign ov_vcount        = vcount_q;
  assign o_headblank_flag = head_q;
  assign o_readout_flag   = read_q;
  assign o_tailblank_flag = tail_q;
  assign o_frame_busy     = busy_q;
  assign o_frame_done     = done_q;
  assign o_start_ignored  = ign_q;

endmodule

// File: doc/ccd_vtransfer_sched.md
Name: ccd_vtransfer_sched

Overview:
Frame-level scheduler for the CCD vertical-transfer path. On a frame start it latches the frame geometry and generates the horizontal line counter. It then steps through head-blank, readout and tail-blank phases, driving the phase flags and counters consumed by the blank-run XV generators and the readout-line timing block. It sits between the register bank / trigger logic and the per-phase XV generators.

Parameters:
REG_WD, 16, width of the geometry registers and of the hcount/vcount outputs.
HPERIOD_MIN, 2, lower clamp for the latched line period.

Ports:
clk  in  1  system clock.
reset  in  1  reset, synchronous and active-high.
i_frame_start  in  1  single-cycle frame request; honoured only in IDLE.
i_abort  in  1  synchronous abort of the frame in progress.
iv_hperiod  in  REG_WD  line period in clk cycles.
iv_headblank_lines  in  REG_WD  number of head-blank lines.
iv_readout_lines  in  REG_WD  number of readout lines.
iv_tailblank_lines  in  REG_WD  number of tail-blank lines.
ov_hcount  out  REG_WD  horizontal count within the current line.
ov_vcount  out  REG_WD  line index within the current phase.
o_headblank_flag  out  1  high for the whole head-blank phase.
o_readout_flag  out  1  high for the whole readout phase.
o_tailblank_flag  out  1  high for the whole tail-blank phase.
o_frame_busy  out  1  high whenever the state is not IDLE.
o_frame_done  out  1  one-cycle pulse at normal frame completion.
o_start_ignored  out  1  one-cycle pulse when i_frame_start arrives while busy.

Behaviour:
- Reset (synchronous, active-high, highest priority): state IDLE. All outputs 0. All shadow registers 0.
- States: IDLE, HEAD, READ, TAIL. Encoding lives in the package.
- In IDLE on i_frame_start:
  - Latch hperiod_s = max(iv_hperiod, HPERIOD_MIN) and the three line counts.
  - Next state is the first of HEAD/READ/TAIL whose latched count is non-zero.
  - If all three counts are 0: stay in IDLE and pulse o_frame_done the next cycle.
- Latency: start sampled at cycle T. At T+1 the state is the first phase, its flag is 1, hcount=0, vcount=0, busy=1.
- hcount:
  - Counts 0..hperiod_s-1 and wraps while busy; held at 0 in IDLE.
  - line_end = busy and (hcount == hperiod_s-1).
- vcount:
  - Reset to 0 on every phase entry.
  - Increments on line_end.
  - On line_end with vcount == phase_count-1, move to the next phase with a non-zero latched count, or to IDLE if none remains.
- Entering IDLE from TAIL (or from the last non-zero phase) pulses o_frame_done for exactly 1 cycle. At that cycle busy=0, flags=0, hcount=0.
- Flags are registered, one-hot, and decoded from the state. At most one flag is high at any time.
- Phase transitions are back-to-back: the new phase flag rises in the cycle immediately after the old one falls, with hcount=0.
- Input registers may change mid-frame with no effect; only the latched shadow values are used.
- i_abort:
  - When busy, next cycle goes to IDLE with all outputs 0 and no done pulse.
  - i_abort has priority over line_end and i_frame_start in the same cycle.
  - i_abort in IDLE is a no-op. If i_abort and i_frame_start arrive together in IDLE, the start is dropped.
- i_frame_start while busy: ignored, and o_start_ignored pulses for 1 cycle.
- Done/start overlap: a start in the same cycle as the final line_end is treated as busy (ignored, pulse). A start in the cycle where o_frame_done is high is accepted.
- Arithmetic: all compares are REG_WD unsigned. Compute count-1 once into a registered shadow at latch time.

Decomposition:
- Package ccd_vsched_pkg holds the state encoding constants (S_IDLE..S_TAIL), REG_WD default and HPERIOD_MIN.
- One sub-module, ccd_line_timer:
  - Implements the hcount wrap counter with enable, clear and period input.
  - Produces the line_end output.
- The FSM, vcount and flag decode stay in the top-level block.

Test Plan:
- Nominal frame: period=10, head=2, read=3, tail=1, start at cycle 0.
  - Head flag high cycles 1-20, readout flag 21-50, tail flag 51-60.
  - o_frame_done pulses at cycle 61.
  - hcount wraps 9→0 each line; vcount runs 0,1 / 0,1,2 / 0.
- Zero-length phases: head=0, read=2, tail=0, period=4. Readout flag high cycles 1-8, done at cycle 9. All-zero counts give done at cycle 1 with busy never set.
- Abort mid-readout at cycle 30 of the nominal frame: cycle 31 has all flags 0, busy 0, hcount 0, no done pulse. A new start at cycle 32 then runs a full frame.
- Start while busy at cycle 15: o_start_ignored pulses at cycle 16 and frame timing is unchanged.
- Start coincident with done (cycle 61): accepted, and the new head phase begins at cycle 62.
- Clamp and shadowing: iv_hperiod=1 gives a 2-cycle line. Changing iv_readout_lines from 3 to 7 during the head phase leaves readout at 3 lines.
- Reset mid-frame: reset asserted at cycle 25 gives all outputs 0 at cycle 26, and the frame is not resumed.
